// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
// Holds the active-low hex glyph table ({a,b,c,d,e,f,g}, a at MSB),
// the all-segments-off pattern, and the slot state type.
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex-to-seven-segment decoder.
//   nibble_i : 4-bit hex digit
//   seg_o    : active-low segments {a,b,c,d,e,f,g}
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb seg_o = GLYPH[nibble_i];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment display scanner.
// Each digit gets REFRESH_DIV clocks; the first BLANK_CYCLES of each slot
// blank everything to prevent ghosting. New data is staged by load and
// committed to the shadow copy only at a frame boundary (cnt=0, idx=0).
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   value        : 4 bits per digit, digit 0 least significant
//   dp, blank    : per-digit decimal point request / forced blank
//   lz_en        : leading-zero suppression enable
//   load         : strobe capturing value/dp/blank/lz_en into staging
//   load_ack     : pulse when staged data commits (with frame_start)
//   seg, dp_n    : active-low segments and decimal point
//   an           : active-low digit enables
//   frame_start  : pulse on the first output cycle of each frame
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic                    load,
  output logic                    load_ack,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam scan_state_e RST_STATE = (BLANK_CYCLES > 0) ? GUARD : DRIVE;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  scan_state_e             state_q, state_d;

  logic [4*NUM_DIGITS-1:0] stg_value_q, stg_value_d, sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d, sh_blank_q, sh_blank_d;
  logic                    stg_lz_q, stg_lz_d, sh_lz_q, sh_lz_d;
  logic                    pending_q, pending_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;
  logic                    load_ack_q, load_ack_d;

  logic                    boundary;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_run;
  logic [3:0]              nib;
  logic                    suppress;
  logic                    dp_sel;
  logic [6:0]              glyph;

  sevenseg_hex_decode u_decode (
    .nibble_i (nib),
    .seg_o    (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      state_q       <= RST_STATE;
      stg_value_q   <= '0;
      stg_dp_q      <= '0;
      stg_blank_q   <= '0;
      stg_lz_q      <= 1'b0;
      sh_value_q    <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '0;
      sh_lz_q       <= 1'b0;
      pending_q     <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_n_q        <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      stg_value_q   <= stg_value_d;
      stg_dp_q      <= stg_dp_d;
      stg_blank_q   <= stg_blank_d;
      stg_lz_q      <= stg_lz_d;
      sh_value_q    <= sh_value_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      sh_lz_q       <= sh_lz_d;
      pending_q     <= pending_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
      load_ack_q    <= load_ack_d;
    end
  end

  assign boundary = (cnt_q == '0) && (idx_q == '0);

  // Slot counter, digit index and the state that will accompany cnt_d.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    state_d = (32'(cnt_d) < BLANK_CYCLES) ? GUARD : DRIVE;
  end

  // Staging / shadow handoff. Commit of old pending data is evaluated before
  // the load so a load on the boundary cycle stays pending for the next frame.
  always_comb begin
    stg_value_d = stg_value_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    stg_lz_d    = stg_lz_q;
    sh_value_d  = sh_value_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    sh_lz_d     = sh_lz_q;
    pending_d   = pending_q;
    if (boundary && pending_q) begin
      sh_value_d = stg_value_q;
      sh_dp_d    = stg_dp_q;
      sh_blank_d = stg_blank_q;
      sh_lz_d    = stg_lz_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      stg_value_d = value;
      stg_dp_d    = dp;
      stg_blank_d = blank;
      stg_lz_d    = lz_en;
      pending_d   = 1'b1;
    end
  end

  // Display path reads the next shadow value, so the boundary cycle itself
  // already shows the newly committed frame.
  always_comb begin
    lz_run  = sh_lz_d;
    lz_mask = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (sh_value_d[4*(NUM_DIGITS-1-k) +: 4] != 4'h0) lz_run = 1'b0;
      lz_mask[NUM_DIGITS-1-k] = lz_run && (k != NUM_DIGITS - 1);
    end

    nib      = '0;
    suppress = 1'b0;
    dp_sel   = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib      = sh_value_d[4*i +: 4];
        suppress = sh_blank_d[i] | lz_mask[i];
        dp_sel   = sh_dp_d[i];
      end
    end

    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    an_d   = '1;
    if (state_q == DRIVE) begin
      seg_d  = suppress ? SEG_OFF : glyph;
      dp_n_d = ~dp_sel;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IW'(i));
      end
    end
    frame_start_d = boundary;
    load_ack_d    = boundary && pending_q;
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign load_ack    = load_ack_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan (4 digits, 8 clocks/slot, 2 guard).
// Expected outputs come from a frame-level model: internal cycle c maps to
// digit (c mod 32)/8 and slot (c mod 32) mod 8; the data shown in a frame is
// the latest load issued strictly before that frame's boundary cycle.
module tb_sevenseg_scan;

  localparam int ND = 4, RD = 8, BC = 2, FRAME = ND * RD;

  localparam logic [6:0] GL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0, blank = '0;
  logic        lz_en = 1'b0, load = 1'b0;
  logic        load_ack, dp_n, frame_start;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;
  int edges = 0;

  typedef struct {
    int          cyc;
    logic [15:0] v;
    logic [3:0]  dpm;
    logic [3:0]  blm;
    logic        lz;
  } load_t;
  load_t loads[$];

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       fs;
    logic       ack;
  } obs_t;

  obs_t got, exp_o;

  sevenseg_scan #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp          (dp),
    .blank       (blank),
    .lz_en       (lz_en),
    .load        (load),
    .load_ack    (load_ack),
    .seg         (seg),
    .dp_n        (dp_n),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release; at a falling edge the
  // outputs reflect internal cycle edges-1 and a new input lands in cycle edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic obs_t model(int c);
    obs_t        e;
    int          b, pos, d, slot;
    logic [15:0] v = '0;
    logic [3:0]  dpm = '0, blm = '0;
    logic        lz = 1'b0, ackx = 1'b0, supp;
    b    = (c / FRAME) * FRAME;
    pos  = c % FRAME;
    d    = pos / RD;
    slot = pos % RD;
    foreach (loads[k]) begin
      if (loads[k].cyc < b) begin
        v = loads[k].v; dpm = loads[k].dpm; blm = loads[k].blm; lz = loads[k].lz;
        if (loads[k].cyc >= b - FRAME) ackx = 1'b1;
      end
    end
    e.fs  = (pos == 0);
    e.ack = (pos == 0) && ackx;
    if (slot < BC) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1;
    end else begin
      e.an   = 4'hF & ~(4'b0001 << d);
      supp   = blm[d] || (lz && d > 0 && (v >> (4 * d)) == 16'h0);
      e.seg  = supp ? 7'h7F : GL[4'(v >> (4 * d))];
      e.dp_n = !dpm[d];
    end
    return e;
  endfunction

  task automatic drive_load(logic [15:0] v, logic [3:0] d, logic [3:0] b, logic l);
    load_t r;
    value = v; dp = d; blank = b; lz_en = l; load = 1'b1;
    r.cyc = edges; r.v = v; r.dpm = d; r.blm = b; r.lz = l;
    loads.push_back(r);
  endtask

  task automatic align_to(int p);
    for (int k = 0; k < 2 * FRAME && (edges % FRAME) != p; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp_n, frame_start, load_ack} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got=%b required=%b", {an, seg, dp_n, frame_start, load_ack},
               {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    loads.delete();
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || load_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_frame fs=%b ack=%b required fs=1 ack=0", frame_start, load_ack);
    end
  endtask

  task automatic test_digits;
    drive_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    for (int j = 0; j < 3 * FRAME; j++) begin
      @(negedge clk);
      load = 1'b0;
      got = {an, seg, dp_n, frame_start, load_ack}; exp_o = model(edges - 1);
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL digits c=%0d got=%b required=%b", edges - 1, got, exp_o);
      end
    end
  endtask

  task automatic test_lz;
    for (int pass = 0; pass < 2; pass++) begin
      drive_load(16'h0030, 4'h0, 4'h0, pass == 0);
      for (int j = 0; j < 70; j++) begin
        @(negedge clk);
        load = 1'b0;
        got = {an, seg, dp_n, frame_start, load_ack}; exp_o = model(edges - 1);
        checks++;
        if (got !== exp_o) begin
          failures++;
          $display("FAIL leading_zero lz=%0d c=%0d got=%b required=%b", pass == 0, edges - 1, got, exp_o);
        end
      end
    end
  endtask

  task automatic test_latest_wins;
    int acks = 0;
    align_to(10);
    drive_load(16'h1111, 4'h0, 4'h0, 1'b0);
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      load = 1'b0;
      if (j == 15) drive_load(16'h2222, 4'h0, 4'h0, 1'b0);
      got = {an, seg, dp_n, frame_start, load_ack}; exp_o = model(edges - 1);
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL latest_wins c=%0d got=%b required=%b", edges - 1, got, exp_o);
      end
      if (load_ack === 1'b1) acks++;
      checks++;
      if (an !== 4'hF && seg === GL[1]) begin
        failures++;
        $display("FAIL latest_wins_no_ones c=%0d seg=%b required not %b", edges - 1, seg, GL[1]);
      end
    end
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("FAIL latest_wins_ack_count got=%0d required=1", acks);
    end
  endtask

  task automatic test_boundary_load;
    int l_cyc, ack_cyc = -1, acks = 0;
    align_to(0);
    l_cyc = edges;
    drive_load(16'h5A3C, 4'h0, 4'h0, 1'b0);
    for (int j = 0; j < 70; j++) begin
      @(negedge clk);
      load = 1'b0;
      got = {an, seg, dp_n, frame_start, load_ack}; exp_o = model(edges - 1);
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL boundary_load c=%0d got=%b required=%b", edges - 1, got, exp_o);
      end
      if (load_ack === 1'b1) begin acks++; ack_cyc = edges - 1; end
    end
    checks++;
    if (acks !== 1 || ack_cyc !== l_cyc + FRAME) begin
      failures++;
      $display("FAIL boundary_load_ack acks=%0d at=%0d required 1 at %0d", acks, ack_cyc, l_cyc + FRAME);
    end
  endtask

  task automatic test_blank_dp;
    int cb;
    cb = ((edges / FRAME) + 1) * FRAME;
    drive_load(16'($urandom), 4'b0100, 4'b0100, 1'b0);
    for (int j = 0; j < 70; j++) begin
      @(negedge clk);
      load = 1'b0;
      got = {an, seg, dp_n, frame_start, load_ack}; exp_o = model(edges - 1);
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL blank_dp c=%0d got=%b required=%b", edges - 1, got, exp_o);
      end
      if (edges - 1 >= cb && an !== 4'hF) begin
        checks++;
        if (an === 4'b1011 && (seg !== 7'h7F || dp_n !== 1'b0)) begin
          failures++;
          $display("FAIL blank_dp_digit2 seg=%b dp_n=%b required 1111111/0", seg, dp_n);
        end else if (an !== 4'b1011 && dp_n !== 1'b1) begin
          failures++;
          $display("FAIL blank_dp_others an=%b dp_n=%b required 1", an, dp_n);
        end
      end
    end
  endtask

  task automatic test_random;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      load = 1'b0;
      got = {an, seg, dp_n, frame_start, load_ack}; exp_o = model(edges - 1);
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL random c=%0d got=%b required=%b", edges - 1, got, exp_o);
      end
      if (j < 340 && $urandom_range(0, 19) == 0)
        drive_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_midframe_reset;
    align_to(15);
    drive_load(16'hBEEF, 4'hF, 4'h0, 1'b0);
    @(negedge clk);
    load = 1'b0;
    align_to(2 * RD + 5);
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({an, seg, dp_n, frame_start, load_ack} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL midframe_reset_hold j=%0d got=%b", j, {an, seg, dp_n, frame_start, load_ack});
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    loads.delete();
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      got = {an, seg, dp_n, frame_start, load_ack}; exp_o = model(edges - 1);
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL midframe_reset c=%0d got=%b required=%b", edges - 1, got, exp_o);
      end
      if (j == 0) begin
        checks++;
        if (frame_start !== 1'b1 || load_ack !== 1'b0) begin
          failures++;
          $display("FAIL midframe_reset_release fs=%b ack=%b required fs=1 ack=0", frame_start, load_ack);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_digits();
    test_lz();
    test_latest_wins();
    test_boundary_load();
    test_blank_dp();
    test_random();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clocks per digit slot, legal range at least BLANK_CYCLES+1.
REQ-003 SHALL have parameter BLANK_CYCLES, default 2, anti-ghosting guard clocks at the start of each slot, legal range 0 or more.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 value  in  4*NUM_DIGITS  hex nibbles; digit i is value[4i+3:4i]; digit 0 is least significant.
REQ-007 dp  in  NUM_DIGITS  decimal point request per digit, active-high.
REQ-008 blank  in  NUM_DIGITS  forced-blank mask per digit, active-high.
REQ-009 lz_en  in  1  leading-zero suppression enable.
REQ-010 load  in  1  single-cycle strobe that captures value, dp, blank and lz_en into staging.
REQ-011 load_ack  out  1  one-cycle pulse when staged data commits to the display.
REQ-012 seg  out  7  segments {a,b,c,d,e,f,g}, a at MSB, active-low.
REQ-013 dp_n  out  1  decimal point, active-low.
REQ-014 an  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all high.
REQ-015 frame_start  out  1  one-cycle pulse at the start of each scan frame.

Function
REQ-016 Internal slot counter cnt SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit index idx SHALL increment, wrapping from NUM_DIGITS-1 to 0.
REQ-017 State machine SHALL be GUARD while cnt<BLANK_CYCLES and DRIVE otherwise; with BLANK_CYCLES=0 it SHALL stay in DRIVE.
REQ-018 In GUARD, an SHALL be all ones, seg SHALL be 7'b1111111 and dp_n SHALL be 1.
REQ-019 In DRIVE, an[idx] SHALL be 0 and all other bits 1; seg SHALL be the glyph of digit idx.
REQ-020 Glyphs, in order 0-F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-021 seg, dp_n, an and frame_start SHALL be registered, lagging the internal cnt/idx state by exactly 1 clock.
REQ-022 A committed blank[i]=1 SHALL force seg to 1111111 for digit i; dp_n SHALL still follow dp[i].
REQ-023 With lz_en=1, digits from NUM_DIGITS-1 downward SHALL be blanked while zero, until the first nonzero digit; digit 0 SHALL never be suppressed.
REQ-024 A frame boundary is the cycle with cnt=0 and idx=0; frame_start SHALL pulse on the corresponding output cycle.
REQ-025 load SHALL write staging and set pending; a further load while pending SHALL overwrite staging (latest wins).
REQ-026 At a frame boundary with pending set, staging SHALL copy to shadow, pending SHALL clear and load_ack SHALL pulse coincident with frame_start.
REQ-027 A load in the same cycle as a frame boundary SHALL commit any previously pending data now; the new data SHALL commit at the next boundary.
REQ-028 The display SHALL use only shadow, so no frame ever mixes old and new data.

Reset
REQ-029 While rst_n=0: seg=1111111, dp_n=1, an all ones, load_ack=0, frame_start=0, cnt=0, idx=0, shadow=0, staging=0, pending=0, state=GUARD (DRIVE if BLANK_CYCLES=0).
REQ-030 Reset mid-frame SHALL discard any pending load without asserting load_ack; the first clock after release SHALL be a frame boundary.

Structure
REQ-031 Shared package sevenseg_pkg SHALL hold the 16 glyph constants, SEG_OFF=7'b1111111 and the GUARD/DRIVE state typedef.
REQ-032 Glyph lookup SHALL be a combinational sub-module sevenseg_hex_decode, 4-bit input to 7-bit active-low output, instantiated once on the selected nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-033 Load value=16'h12AF, then wait one frame -> digit 0..3 DRIVE windows show F=0111000, A=0001000, 2=0010010, 1=1001111, with an=1110,1101,1011,0111, each low for 6 clocks after 2 all-high clocks.
REQ-034 value=16'h0030, lz_en=1 -> digits 3 and 2 show 1111111, digit 1 shows 0000110, digit 0 shows 0000001; with lz_en=0 all four digits are lit.
REQ-035 Load 16'h1111 mid-frame, then 16'h2222 before the boundary -> exactly one load_ack, coincident with frame_start; the next frame shows all 2s and never 1s.
REQ-036 load asserted on the frame-boundary cycle -> no load_ack at that boundary; load_ack at the next boundary, 32 clocks later.
REQ-037 blank=4'b0100, dp=4'b0100 -> digit 2 has seg=1111111 and dp_n=0 in DRIVE; dp_n=1 for the other digits.
REQ-038 Assert rst_n=0 at cnt=5 of digit 2 with a load pending -> outputs go to reset values immediately with no load_ack; frame_start pulses 1 clock after release.
